// File: rtl/uart_tx_fifo_if.sv
// Producer-side bundle for the queued UART transmitter: push handshake plus line/status.
interface uart_tx_fifo_if #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
);
  logic                          trmt;
  logic [DATA_W-1:0]             tx_data;
  logic                          fifo_full;
  logic [$clog2(FIFO_DEPTH):0]   fifo_cnt;
  logic                          ovf;
  logic                          TX;
  logic                          tx_busy;
  logic                          tx_done;

  modport master (
    output trmt, tx_data,
    input  fifo_full, fifo_cnt, ovf, TX, tx_busy, tx_done
  );

  modport slave (
    input  trmt, tx_data,
    output fifo_full, fifo_cnt, ovf, TX, tx_busy, tx_done
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO; queued words leave back-to-back.
// The line is registered from the current state, so TX trails the FSM by one cycle.
module uart_tx_fifo #(
  parameter int DATA_W     = 8,
  parameter int BAUD_DIV   = 2604,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_fifo_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(BAUD_DIV);
  localparam int NW = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_e;

  state_e            state_q;
  logic [BW-1:0]     baud_q;
  logic [NW-1:0]     bit_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     rd_q, wr_q;
  logic [CW-1:0]     cnt_q;
  logic              par_q, tx_q, ovf_q, done_q;

  logic              empty, full, bit_end, last_stop, pop, push;
  logic [DATA_W-1:0] head;

  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == CW'(FIFO_DEPTH));
  assign bit_end   = (baud_q == BW'(BAUD_DIV - 1));
  assign last_stop = (state_q == STOP) && bit_end && (bit_q == NW'(STOP_BITS - 1));
  // Popping at the end of the last stop bit is what removes the idle gap.
  assign pop       = !empty && ((state_q == IDLE) || last_stop);
  assign push      = bus.trmt && (!full || pop);
  assign head      = mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= bus.tx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      ovf_q <= bus.trmt && !push;
      if (push)                    done_q <= 1'b0;
      else if (last_stop && empty) done_q <= 1'b1;

      case (state_q)
        START:   tx_q <= 1'b0;
        DATA:    tx_q <= shift_q[0];
        PAR:     tx_q <= par_q;
        default: tx_q <= 1'b1;
      endcase

      baud_q <= (state_q == IDLE || bit_end) ? '0 : baud_q + BW'(1);

      if (pop) begin
        state_q <= START;
        shift_q <= head;
        par_q   <= (PARITY == 2) ? ~^head : ^head;
        bit_q   <= '0;
      end else begin
        case (state_q)
          START: if (bit_end) begin
            state_q <= DATA;
            bit_q   <= '0;
          end
          DATA: if (bit_end) begin
            shift_q <= shift_q >> 1;
            if (bit_q == NW'(DATA_W - 1)) begin
              bit_q   <= '0;
              state_q <= (PARITY != 0) ? PAR : STOP;
            end else begin
              bit_q <= bit_q + NW'(1);
            end
          end
          PAR: if (bit_end) begin
            state_q <= STOP;
            bit_q   <= '0;
          end
          STOP: if (bit_end) begin
            if (last_stop) state_q <= IDLE;
            else           bit_q   <= bit_q + NW'(1);
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.TX        = tx_q;
  assign bus.ovf       = ovf_q;
  assign bus.tx_done   = done_q;
  assign bus.tx_busy   = (state_q != IDLE);
  assign bus.fifo_cnt  = cnt_q;
  assign bus.fifo_full = full;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Four transmitter configurations checked every cycle against a frame-level model,
// plus literal line/timing expectations for the directed scenarios.
module tb_uart_tx_fifo;
  localparam int BAUD  = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DATA_W(8), .FIFO_DEPTH(DEPTH)) if0(), if1(), if2();
  uart_tx_fifo_if #(.DATA_W(7), .FIFO_DEPTH(DEPTH)) if3();

  uart_tx_fifo #(.DATA_W(8), .BAUD_DIV(BAUD), .FIFO_DEPTH(DEPTH), .PARITY(0), .STOP_BITS(1))
    u0 (.clk(clk), .rst(rst), .bus(if0));
  uart_tx_fifo #(.DATA_W(8), .BAUD_DIV(BAUD), .FIFO_DEPTH(DEPTH), .PARITY(1), .STOP_BITS(1))
    u1 (.clk(clk), .rst(rst), .bus(if1));
  uart_tx_fifo #(.DATA_W(8), .BAUD_DIV(BAUD), .FIFO_DEPTH(DEPTH), .PARITY(2), .STOP_BITS(1))
    u2 (.clk(clk), .rst(rst), .bus(if2));
  uart_tx_fifo #(.DATA_W(7), .BAUD_DIV(BAUD), .FIFO_DEPTH(DEPTH), .PARITY(0), .STOP_BITS(2))
    u3 (.clk(clk), .rst(rst), .bus(if3));

  logic       trmt [4];
  logic [7:0] din  [4];
  logic       tx [4], busy [4], done [4], ovf [4], full [4];
  logic [2:0] cnt [4];

  assign if0.trmt = trmt[0]; assign if0.tx_data = din[0];
  assign if1.trmt = trmt[1]; assign if1.tx_data = din[1];
  assign if2.trmt = trmt[2]; assign if2.tx_data = din[2];
  assign if3.trmt = trmt[3]; assign if3.tx_data = din[3][6:0];

  assign tx[0] = if0.TX; assign busy[0] = if0.tx_busy; assign done[0] = if0.tx_done;
  assign ovf[0] = if0.ovf; assign full[0] = if0.fifo_full; assign cnt[0] = if0.fifo_cnt;
  assign tx[1] = if1.TX; assign busy[1] = if1.tx_busy; assign done[1] = if1.tx_done;
  assign ovf[1] = if1.ovf; assign full[1] = if1.fifo_full; assign cnt[1] = if1.fifo_cnt;
  assign tx[2] = if2.TX; assign busy[2] = if2.tx_busy; assign done[2] = if2.tx_done;
  assign ovf[2] = if2.ovf; assign full[2] = if2.fifo_full; assign cnt[2] = if2.fifo_cnt;
  assign tx[3] = if3.TX; assign busy[3] = if3.tx_busy; assign done[3] = if3.tx_done;
  assign ovf[3] = if3.ovf; assign full[3] = if3.fifo_full; assign cnt[3] = if3.fifo_cnt;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame-level model: remaining frame cycles per instance, plus a word queue.
  int dw [4] = '{8, 8, 8, 7};
  int pm [4] = '{0, 1, 2, 0};
  int sb [4] = '{1, 1, 1, 2};
  int         rem [4];
  logic [7:0] cur [4];
  logic [7:0] q [4][$];
  logic       e_tx [4], e_done [4], e_ovf [4];

  function automatic int flen(int i);
    return (1 + dw[i] + ((pm[i] != 0) ? 1 : 0) + sb[i]) * BAUD;
  endfunction

  function automatic logic fbit(int i, logic [7:0] w, int p);
    int b;
    b = p / BAUD;
    if (b == 0) return 1'b0;
    if (b <= dw[i]) return w[b-1];
    if (pm[i] != 0 && b == dw[i] + 1) return (pm[i] == 1) ? ^w : ~^w;
    return 1'b1;
  endfunction

  task automatic mstep(int i);
    int         lb;
    bit         fin, popd, acc;
    logic [7:0] w;
    lb = rem[i]; fin = 0; popd = 0;
    if (rst) begin
      q[i].delete(); rem[i] = 0;
      e_tx[i] = 1'b1; e_done[i] = 1'b0; e_ovf[i] = 1'b0;
      return;
    end
    e_tx[i] = (lb > 0) ? fbit(i, cur[i], flen(i) - lb) : 1'b1;
    if (lb == 1) begin fin = 1; rem[i] = 0; end
    else if (lb > 1) rem[i] = lb - 1;
    if (rem[i] == 0 && q[i].size() > 0) begin
      cur[i] = q[i].pop_front(); rem[i] = flen(i); popd = 1;
    end
    acc = trmt[i] && (q[i].size() < DEPTH);
    w = din[i] & 8'((1 << dw[i]) - 1);
    if (acc) q[i].push_back(w);
    e_ovf[i] = trmt[i] && !acc;
    if (acc) e_done[i] = 1'b0;
    else if (fin && !popd) e_done[i] = 1'b1;
  endtask

  initial forever begin
    @(posedge clk);
    for (int i = 0; i < 4; i++) mstep(i);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("m%0d.tx", i),   32'(tx[i]),   32'(e_tx[i]));
      chk($sformatf("m%0d.busy", i), 32'(busy[i]), 32'(rem[i] != 0));
      chk($sformatf("m%0d.done", i), 32'(done[i]), 32'(e_done[i]));
      chk($sformatf("m%0d.ovf", i),  32'(ovf[i]),  32'(e_ovf[i]));
      chk($sformatf("m%0d.cnt", i),  32'(cnt[i]),  32'(q[i].size()));
      chk($sformatf("m%0d.full", i), 32'(full[i]), 32'(q[i].size() == DEPTH));
    end
  end

  task automatic tick;
    @(negedge clk);
  endtask

  int a5 [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

  initial begin
    int t, gaps;
    for (int i = 0; i < 4; i++) begin trmt[i] = 1'b0; din[i] = '0; end
    repeat (3) tick();
    chk("rst_tx", 32'(tx[0]), 1);
    chk("rst_cnt", 32'(cnt[0]), 0);
    chk("rst_busy", 32'(busy[0]), 0);
    chk("rst_done", 32'(done[0]), 0);
    rst = 1'b0;
    tick();

    // single 0xA5 frame
    trmt[0] = 1'b1; din[0] = 8'hA5; tick(); trmt[0] = 1'b0;
    chk("t1_tx_e0", 32'(tx[0]), 1);
    for (int k = 1; k <= 44; k++) begin
      tick();
      if (k == 1) begin chk("t1_tx_e1", 32'(tx[0]), 1); chk("t1_busy", 32'(busy[0]), 1); end
      if (k == 2) chk("t1_start_edge", 32'(tx[0]), 0);
      if (k >= 4 && k <= 40 && (k % 4) == 0)
        chk($sformatf("t1_bit%0d", (k - 4) / 4), 32'(tx[0]), 32'(a5[(k - 4) / 4]));
      if (k == 40) chk("t1_done_early", 32'(done[0]), 0);
      if (k == 41) chk("t1_done_edge", 32'(done[0]), 1);
    end

    // six-cycle burst into a 4-deep FIFO
    for (int k = 0; k < 6; k++) begin
      trmt[0] = 1'b1; din[0] = 8'(k + 1); tick();
      chk($sformatf("t2_ovf%0d", k), 32'(ovf[0]), 32'(k == 5));
    end
    trmt[0] = 1'b0;
    chk("t2_full_cnt", 32'(cnt[0]), 4);
    t = 5; gaps = 0;
    while (!done[0] && t < 400) begin
      tick(); t++;
      if (!busy[0] && !done[0]) gaps++;
    end
    chk("t2_done_edge", 32'(t), 201);
    chk("t2_gaps", 32'(gaps), 0);

    // parity and two-stop-bit framing
    tick();
    trmt[1] = 1'b1; trmt[2] = 1'b1; trmt[3] = 1'b1;
    din[1] = 8'h07; din[2] = 8'h07; din[3] = 8'h7F;
    tick();
    trmt[1] = 1'b0; trmt[2] = 1'b0; trmt[3] = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      tick();
      if (k == 40) begin
        chk("t3_even_par", 32'(tx[1]), 1);
        chk("t3_odd_par", 32'(tx[2]), 0);
        chk("t4_stop2", 32'(tx[3]), 1);
        chk("t4_done_early", 32'(done[3]), 0);
      end
      if (k == 44) chk("t3_done_early", 32'(done[1]), 0);
      if (k == 45) begin
        chk("t3_even_done", 32'(done[1]), 1);
        chk("t3_odd_done", 32'(done[2]), 1);
      end
      if (k == 32) chk("t4_bit6", 32'(tx[3]), 1);
      if (k == 36) chk("t4_stop1", 32'(tx[3]), 1);
      if (k == 41) chk("t4_done_edge", 32'(done[3]), 1);
    end

    // push into a full FIFO on the pop edge
    for (int k = 0; k < 5; k++) begin
      trmt[0] = 1'b1; din[0] = 8'(8'h30 + k); tick();
    end
    trmt[0] = 1'b0;
    repeat (36) tick();
    chk("t5_pre_cnt", 32'(cnt[0]), 4);
    chk("t5_pre_full", 32'(full[0]), 1);
    trmt[0] = 1'b1; din[0] = 8'h99; tick(); trmt[0] = 1'b0;
    chk("t5_cnt", 32'(cnt[0]), 4);
    chk("t5_ovf", 32'(ovf[0]), 0);
    chk("t5_full", 32'(full[0]), 1);
    t = 0;
    while (!done[0] && t < 600) begin tick(); t++; end
    chk("t5_drained", 32'(done[0]), 1);

    // reset mid-frame with entries queued
    tick();
    for (int k = 0; k < 3; k++) begin
      trmt[0] = 1'b1; din[0] = 8'(8'h11 * (k + 1)); tick();
    end
    trmt[0] = 1'b0;
    chk("t6_queued", 32'(cnt[0]), 2);
    repeat (16) tick();
    rst = 1'b1; tick();
    chk("t6_tx", 32'(tx[0]), 1);
    chk("t6_cnt", 32'(cnt[0]), 0);
    chk("t6_busy", 32'(busy[0]), 0);
    chk("t6_done", 32'(done[0]), 0);
    rst = 1'b0;
    gaps = 0;
    repeat (100) begin
      tick();
      if (busy[0] || !tx[0]) gaps++;
    end
    chk("t6_silent", 32'(gaps), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
